car_link_responder: RTL
=======================

Name: car_link_responder

Overview:
Vehicle-side end of the controller/car UART link. It receives the 8-bit command frame {2'b10, destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward}, validates and decodes it into registered drive/barrier outputs, and periodically transmits the 4 detector readings back as a status byte. The block serves as the bench-side car model and as the responder half of the controller link.

Parameters:
CLKS_PER_BIT, 10416, sys_clk cycles per UART bit (100 MHz / 9600 baud)
TX_PERIOD, 1000000, sys_clk cycles between status-byte launches (10 ms)
TIMEOUT_CLKS, 50000000, cycles without a valid frame before commands are dropped (0.5 s)

Ports:
sys_clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-low reset
rxd  in  1  UART line from controller, idle high, asynchronous
txd  out  1  UART line to controller, idle high
front_det  in  1  front obstacle present
left_det  in  1  left obstacle present
right_det  in  1  right obstacle present
back_det  in  1  back obstacle present
move_forward  out  1  decoded command
move_backward  out  1  decoded command
turn_left  out  1  decoded command
turn_right  out  1  decoded command
place_barrier  out  1  decoded command
destroy_barrier  out  1  decoded command
cmd_valid  out  1  1-cycle pulse on accepted frame
frame_err  out  1  1-cycle pulse on rejected frame
link_alive  out  1  high while frames arrive within TIMEOUT_CLKS

Behaviour:
- Reset (rst=0, async): txd=1, all command outputs 0, cmd_valid=0, frame_err=0, link_alive=0, all counters and FSMs to IDLE.
- rxd passes a 2-flop synchronizer; all RX timing references the synchronized signal.
- RX FSM: IDLE -> START on falling edge; START waits CLKS_PER_BIT/2 (integer division), resamples: low -> DATA, high -> IDLE (glitch, no pulse). DATA samples 8 bits LSB-first, CLKS_PER_BIT apart. STOP samples one bit later, then returns to IDLE.
- Accept: stop bit 1 and byte[7:6]==2'b10. Command outputs update and cmd_valid pulses in the cycle after the stop sample. Otherwise frame_err pulses in that cycle and outputs hold.
- Conflict decode: byte[0]&byte[1] both set -> move_forward=move_backward=0; byte[2]&byte[3] both set -> turn_left=turn_right=0. Barrier bits pass unchanged.
- Outputs are registered and hold until the next accepted frame, timeout, or reset.
- Watchdog: counter clears on every accepted frame, otherwise increments, saturating at TIMEOUT_CLKS. On reaching TIMEOUT_CLKS, all six command outputs clear to 0 and link_alive=0. link_alive=1 from the cycle of each accepted frame. Rejected frames do not refresh the watchdog.
- TX period counter is free-running, 0..TX_PERIOD-1. At wrap it raises a launch request.
- TX FSM: IDLE -> START -> DATA(8, LSB-first) -> STOP -> IDLE. Each bit lasts CLKS_PER_BIT cycles. txd is registered.
- TX launch snapshots the status byte {4'b0000, back_det, right_det, left_det, front_det} into the shift register. Detector changes during a frame do not affect it.
- A launch request arriving while TX is busy is held in a 1-deep pending flag and sent right after STOP. Further requests while pending are merged and never queued beyond 1.
- RX and TX are fully independent; simultaneous activity is legal.
- A reset assertion mid-frame aborts both FSMs immediately. txd returns to 1 and no pulse is emitted.

Test Plan (CLKS_PER_BIT=16, TX_PERIOD=400, TIMEOUT_CLKS=2000):
- Send 8'b1000_0101 with a valid stop -> move_forward=1, turn_left=1, others 0. cmd_valid pulses once in the cycle after the stop sample. link_alive=1.
- Send 8'b0100_0001 -> frame_err pulses, outputs unchanged. Send 8'b1000_0001 with stop bit 0 -> frame_err pulses, outputs unchanged.
- Send 8'b1000_1111 -> all four drive/turn outputs 0 (conflicts), barriers 0. Send 8'b1011_0000 -> place_barrier=destroy_barrier=1.
- Drive front_det=1, right_det=1 -> txd carries 8'h05 LSB-first with a start and stop bit every 400 cycles. Toggling left_det mid-frame leaves the current byte at 8'h05.
- After an accepted 8'h81, send nothing for 2000 cycles -> all commands 0 and link_alive=0. The next valid frame restores them.
- Hold rxd low 4 cycles (glitch) -> no pulse, RX back to IDLE. Assert rst mid-TX -> txd=1 immediately, and transmission restarts on the next period wrap.

Source files
------------

// File: rtl/car_link_responder.sv
// Vehicle-side UART responder: decodes controller command frames into registered
// drive/barrier outputs and periodically reports the four detector readings.
module car_link_responder #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned TX_PERIOD    = 1000000,
  parameter int unsigned TIMEOUT_CLKS = 50000000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  input  logic front_det,
  input  logic left_det,
  input  logic right_det,
  input  logic back_det,
  output logic move_forward,
  output logic move_backward,
  output logic turn_left,
  output logic turn_right,
  output logic place_barrier,
  output logic destroy_barrier,
  output logic cmd_valid,
  output logic frame_err,
  output logic link_alive
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned PW = $clog2(TX_PERIOD + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(TX_PERIOD - 1);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t       rx_state, rx_next;
  logic            rx_meta, rx_sync, rx_prev;
  logic [BW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_tick, rx_half_tick;
  logic            rx_sample_bit, rx_stop_sample, rx_cnt_clr;
  logic            frame_ok, accept, reject;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_tick      = (rx_cnt == BIT_LAST);
  assign rx_half_tick = (rx_cnt == HALF_LAST);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_sample_bit  = (rx_state == RX_DATA) && rx_tick;
    rx_stop_sample = (rx_state == RX_STOP) && rx_tick;
    rx_cnt_clr     = (rx_state == RX_IDLE) || (rx_next != rx_state) || rx_sample_bit;
    frame_ok       = rx_sync && (rx_shift[7:6] == 2'b10);
    accept         = rx_stop_sample && frame_ok;
    reject         = rx_stop_sample && !frame_ok;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
      if (rx_sample_bit) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // ------------------------------------------------ decode, outputs, watchdog
  logic [WW-1:0] wd_cnt;
  logic          wd_expired;

  assign wd_expired = (wd_cnt == WD_LIMIT);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst)               wd_cnt <= '0;
    else if (accept)        wd_cnt <= '0;
    else if (!wd_expired)   wd_cnt <= wd_cnt + 1'b1;
  end

  // Opposing drive or turn bits cancel each other; barrier bits pass straight through.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      move_forward    <= 1'b0;
      move_backward   <= 1'b0;
      turn_left       <= 1'b0;
      turn_right      <= 1'b0;
      place_barrier   <= 1'b0;
      destroy_barrier <= 1'b0;
      link_alive      <= 1'b0;
      cmd_valid       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      cmd_valid <= accept;
      frame_err <= reject;
      if (accept) begin
        move_forward    <= rx_shift[0] & ~rx_shift[1];
        move_backward   <= rx_shift[1] & ~rx_shift[0];
        turn_left       <= rx_shift[2] & ~rx_shift[3];
        turn_right      <= rx_shift[3] & ~rx_shift[2];
        place_barrier   <= rx_shift[4];
        destroy_barrier <= rx_shift[5];
        link_alive      <= 1'b1;
      end else if (wd_expired) begin
        move_forward    <= 1'b0;
        move_backward   <= 1'b0;
        turn_left       <= 1'b0;
        turn_right      <= 1'b0;
        place_barrier   <= 1'b0;
        destroy_barrier <= 1'b0;
        link_alive      <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t       tx_state, tx_next;
  logic [PW-1:0]   per_cnt;
  logic            per_wrap, tx_pending, tx_launch;
  logic [BW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift, tx_shift_next;
  logic            tx_tick, tx_shift_en, tx_line;

  assign per_wrap  = (per_cnt == PER_LAST);
  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign tx_launch = (tx_state == TX_IDLE) && (per_wrap || tx_pending);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      per_cnt    <= '0;
      tx_pending <= 1'b0;
    end else begin
      per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
      if (tx_launch)     tx_pending <= 1'b0;
      else if (per_wrap) tx_pending <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_launch) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // txd is registered, so the line level is derived from the state being entered.
  always_comb begin
    tx_shift_en   = (tx_state == TX_DATA) && tx_tick;
    tx_shift_next = tx_shift;
    if (tx_launch)
      tx_shift_next = {4'b0000, back_det, right_det, left_det, front_det};
    else if (tx_shift_en)
      tx_shift_next = {1'b0, tx_shift[7:1]};
    unique case (tx_next)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift_next[0];
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      txd      <= tx_line;
      tx_shift <= tx_shift_next;
      tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_shift_en) tx_bit <= tx_bit + 1'b1;
    end
  end

endmodule
